wave_shaper: RTL and testbench
==============================

# wave_shaper

Per-sample oscillator waveform generator for the synthesizer datapath. On each `start` it latches a phase counter value and a period value, runs an internal bit-serial restoring divider to get the normalized phase, and produces one 8-bit unsigned sample for the selected waveform: silence, square, triangle or sawtooth. It sits between the phase counter (which supplies `count` and `fd`) and the mixer, which consumes `signal` when `done` pulses.

## Interface
- `CNT_W`, 18: width of `fd` and `count`.
- `OUT_W`, 8: sample width; the normalized quotient width is also `OUT_W`.
- `PHASE_SHIFT`, 6: left shift applied to `count` before division; `CNT_W + PHASE_SHIFT` (24) is the divider width.
- `clk` input 1: single clock; all logic updates on the rising edge.
- `nrst` input 1: reset, synchronous and active-high.
- `start` input 1: request one sample; sampled only in IDLE.
- `fd` input `CNT_W`: waveform period in counter ticks.
- `count` input `CNT_W`: current phase counter value.
- `mode` input 2: 00 silence, 01 square, 10 triangle, 11 sawtooth.
- `signal` output `OUT_W`: registered sample; holds its value between updates.
- `done` output 1: one-cycle pulse when `signal` is updated.

## Operation
- States are IDLE, DIV and OUT.
- IDLE: when `start` is high, latch `fd`, `count` and `mode`, and load the divider. Go to DIV.
  - Dividend = {count, PHASE_SHIFT zeros}.
  - Divisor = zero-extended `fd`.
- DIV: restoring division, one quotient bit per cycle, MSB first, for 24 cycles. Then go to OUT.
- OUT: register `signal`, assert `done` for this cycle only, return to IDLE.
- Quotient q = floor(count*64/fd), saturated to 255 if it exceeds 8 bits.
- `half` = fd >> 1 (floor).
- Sample value by mode:
  - Mode 00: 0.
  - Mode 01: 255 if count > half, else 0.
  - Mode 10: if count > half, (2*q) mod 256; else (128 − 2*q) mod 256.
  - Mode 11: q.
- fd == 0: output is 0 for every mode. No divide is attempted, but the full latency is still spent.
- `count` ≥ `fd` is legal and is computed by the same formulas; no clamping beyond q saturation.
- `start` while in DIV or OUT is ignored and not queued.
- Inputs may change after the sampling edge without affecting the result.

## Timing
- Reset values: `signal` = 0, `done` = 0, state = IDLE, divider registers cleared.
- Reset has priority over everything. Reset mid-operation aborts, gives no `done`, and sets `signal` = 0.
- Latency is fixed for all modes and operands:
  - Edge E samples `start`.
  - Edges E+1 .. E+24 perform the division steps.
  - `done` is high and `signal` is valid in the cycle following edge E+25.
- Back-to-back: a new `start` is accepted in the cycle after `done` at the earliest (IDLE). Throughput is one sample per 26 cycles.
- `start` held high continuously retriggers each time IDLE is reached.

## Configuration
- `WAVE_SHAPER_TRI_EN` defined: mode 10 produces the triangle as specified.
- Not defined: triangle logic is removed and mode 10 outputs 0, like mode 00, with unchanged latency and `done` behaviour.

## Test plan
- Silence: mode 00 with (fd, count) = (0, 0), (12004, 0), (12004, 24464), (0, 24464) → `signal` = 0 each time, and `done` pulses once, 25 edges after the start edge.
- Square threshold: mode 01, fd = 12004.
  - count = 6002 → 0.
  - count = 6003 → 255.
  - count = 244 → 0.
  - count = 12004 or 24624 → 255.
  - fd = 20, count = 11 → 255.
- Triangle (with `WAVE_SHAPER_TRI_EN`):
  - mode 10, fd = 200, count = 30 → q = 9, `signal` = 110.
  - fd = 60, count = 50 → q = 53, `signal` = 106.
  - Without the macro, both → 0.
- Sawtooth:
  - mode 11, fd = 60, count = 50 → 53.
  - fd = 39527, count = 46993 → 76.
  - fd = 1, count = 262143 → 255 (saturated).
- Zero period: fd = 0 in modes 01, 10 and 11 → `signal` = 0 with normal `done` timing.
- Control:
  - `start` pulsed during DIV → ignored; exactly one `done`.
  - `nrst` asserted at DIV step 10 → no `done`, `signal` = 0.
  - A following `start` completes normally.

Source files
------------

// File: rtl/wave_shaper.sv
// wave_shaper: one 8-bit oscillator sample per start, from a bit-serial restoring divider.
// Optional triangle waveform is compiled in only when WAVE_SHAPER_TRI_EN is defined.
module wave_shaper #(
    parameter int CNT_W       = 18,
    parameter int OUT_W       = 8,
    parameter int PHASE_SHIFT = 6
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [CNT_W-1:0] fd,
    input  logic [CNT_W-1:0] count,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] signal,
    output logic             done
);
    localparam int DIV_W  = CNT_W + PHASE_SHIFT;
    localparam int STEP_W = $clog2(DIV_W);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DIV_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_OUT
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [CNT_W-1:0]  r_fd;
    logic [CNT_W-1:0]  r_count;
    logic [1:0]        r_mode;
    logic [DIV_W-1:0]  r_quo;
    logic [DIV_W-1:0]  r_rem;
    logic [STEP_W-1:0] r_step;
    logic [OUT_W-1:0]  r_signal;
    logic              r_done;

    logic [DIV_W:0]    w_rem_shift;
    logic [DIV_W:0]    w_divisor;
    logic [DIV_W-1:0]  w_rem_sub;
    logic              w_ge;
    logic              w_fd_zero;
    logic              w_upper;
    logic [OUT_W-1:0]  w_q_sat;
    logic [OUT_W-1:0]  w_tri;
    logic [OUT_W-1:0]  w_sample;

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_DIV;
            S_DIV:   if (r_step == LAST_STEP) w_state_next = S_OUT;
            S_OUT:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Dividend bits stream out of the top of r_quo while quotient bits fill in from the bottom.
    assign w_rem_shift = {r_rem, r_quo[DIV_W-1]};
    assign w_divisor   = (DIV_W + 1)'(r_fd);
    assign w_ge        = (w_rem_shift >= w_divisor);
    assign w_rem_sub   = w_rem_shift[DIV_W-1:0] - w_divisor[DIV_W-1:0];
    assign w_fd_zero   = (r_fd == '0);

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_fd     <= '0;
            r_count  <= '0;
            r_mode   <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_step   <= '0;
            r_signal <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_fd    <= fd;
                        r_count <= count;
                        r_mode  <= mode;
                        r_quo   <= {count, {PHASE_SHIFT{1'b0}}};
                        r_rem   <= '0;
                        r_step  <= '0;
                    end
                end
                S_DIV: begin
                    r_step <= r_step + STEP_W'(1);
                    // A zero period skips the arithmetic but still spends the full step count.
                    if (!w_fd_zero) begin
                        r_quo <= {r_quo[DIV_W-2:0], w_ge};
                        r_rem <= w_ge ? w_rem_sub : w_rem_shift[DIV_W-1:0];
                    end
                end
                S_OUT: begin
                    r_signal <= w_sample;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_q_sat = (|r_quo[DIV_W-1:OUT_W]) ? '1 : r_quo[OUT_W-1:0];
    assign w_upper = (r_count > (r_fd >> 1));

`ifdef WAVE_SHAPER_TRI_EN
    logic [OUT_W-1:0] w_q2;
    assign w_q2  = {w_q_sat[OUT_W-2:0], 1'b0};
    assign w_tri = w_upper ? w_q2 : (OUT_W'(1 << (OUT_W - 1)) - w_q2);
`else
    assign w_tri = '0;
`endif

    always_comb begin
        w_sample = '0;
        if (!w_fd_zero) begin
            case (r_mode)
                2'b01:   w_sample = w_upper ? '1 : '0;
                2'b10:   w_sample = w_tri;
                2'b11:   w_sample = w_q_sat;
                default: w_sample = '0;
            endcase
        end
    end

    assign signal = r_signal;
    assign done   = r_done;
endmodule

// File: tb/tb_wave_shaper.sv
// Directed-vector bench for wave_shaper: table of single samples plus control sequences.
// Triangle expectations follow WAVE_SHAPER_TRI_EN.
module tb_wave_shaper;
    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        start = 1'b0;
    logic [17:0] fd = '0;
    logic [17:0] count = '0;
    logic [1:0]  mode = '0;
    logic [7:0]  signal;
    logic        done;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    wave_shaper #(.CNT_W(18), .OUT_W(8), .PHASE_SHIFT(6)) dut (
        .clk(clk), .nrst(nrst), .start(start), .fd(fd), .count(count),
        .mode(mode), .signal(signal), .done(done)
    );

    typedef struct {
        logic [17:0] fd;
        logic [17:0] count;
        logic [1:0]  mode;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[$];

`ifdef WAVE_SHAPER_TRI_EN
    localparam logic [7:0] TRI_A = 8'd110;
    localparam logic [7:0] TRI_B = 8'd106;
    localparam logic [7:0] TRI_C = 8'd64;
`else
    localparam logic [7:0] TRI_A = 8'd0;
    localparam logic [7:0] TRI_B = 8'd0;
    localparam logic [7:0] TRI_C = 8'd0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Waits up to 40 edges for done; returns edges elapsed, or 0 if it never came.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic add(input logic [17:0] f, input logic [17:0] c, input logic [1:0] m,
                       input logic [7:0] e);
        vec_t v;
        v.fd = f; v.count = c; v.mode = m; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat;
        @(negedge clk);
        fd = v.fd; count = v.count; mode = v.mode; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        fd = 18'($urandom); count = 18'($urandom); mode = 2'($urandom);
        wait_done(lat);
        check({name, " latency"}, lat, 25);
        check({name, " signal"}, {24'd0, signal}, {24'd0, v.exp});
        @(posedge clk);
        #1;
        check({name, " done pulse"}, {31'd0, done}, 0);
        $display("%s fd=%0d count=%0d mode=%0d -> signal=%0d (exp %0d) lat=%0d",
                 name, v.fd, v.count, v.mode, signal, v.exp, lat);
    endtask

    initial begin
        int lat;
        int ndone;
        int first_lat;

        add(18'd0,     18'd0,      2'd0, 8'd0);
        add(18'd12004, 18'd0,      2'd0, 8'd0);
        add(18'd12004, 18'd24464,  2'd0, 8'd0);
        add(18'd0,     18'd24464,  2'd0, 8'd0);
        add(18'd12004, 18'd6002,   2'd1, 8'd0);
        add(18'd12004, 18'd6003,   2'd1, 8'd255);
        add(18'd12004, 18'd244,    2'd1, 8'd0);
        add(18'd12004, 18'd12004,  2'd1, 8'd255);
        add(18'd12004, 18'd24624,  2'd1, 8'd255);
        add(18'd20,    18'd11,     2'd1, 8'd255);
        add(18'd200,   18'd30,     2'd2, TRI_A);
        add(18'd60,    18'd50,     2'd2, TRI_B);
        add(18'd12004, 18'd6003,   2'd2, TRI_C);
        add(18'd60,    18'd50,     2'd3, 8'd53);
        add(18'd39527, 18'd46993,  2'd3, 8'd76);
        add(18'd1,     18'd262143, 2'd3, 8'd255);
        add(18'd12004, 18'd6002,   2'd3, 8'd32);
        add(18'd0,     18'd5,      2'd1, 8'd0);
        add(18'd0,     18'd5,      2'd2, 8'd0);
        add(18'd0,     18'd5,      2'd3, 8'd0);

        repeat (3) @(posedge clk);
        #1;
        check("reset signal", {24'd0, signal}, 0);
        check("reset done", {31'd0, done}, 0);
        nrst = 1'b0;

        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

        // start pulsed mid-division must be ignored
        @(negedge clk);
        fd = 18'd60; count = 18'd50; mode = 2'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; fd = 18'd1; count = 18'd262143; mode = 2'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0; first_lat = 0;
        for (int k = 7; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ndone++;
                if (first_lat == 0) first_lat = k;
            end
        end
        check("ignore start dones", ndone, 1);
        check("ignore start latency", first_lat, 25);
        check("ignore start signal", {24'd0, signal}, 53);
        $display("ignore-start: dones=%0d latency=%0d signal=%0d", ndone, first_lat, signal);

        // reset at division step 10 aborts the sample
        @(negedge clk);
        fd = 18'd1; count = 18'd262143; mode = 2'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        nrst = 1'b1;
        @(posedge clk);
        #1;
        nrst = 1'b0;
        check("abort signal", {24'd0, signal}, 0);
        check("abort done", {31'd0, done}, 0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        check("abort no done", ndone, 0);
        $display("abort: dones=%0d signal=%0d", ndone, signal);

        run_vec("post-abort", vecs[15]);

        // start held high retriggers every 26 cycles, latching fresh operands
        @(negedge clk);
        fd = 18'd60; count = 18'd50; mode = 2'd3; start = 1'b1;
        @(posedge clk);
        #1;
        fd = 18'd1; count = 18'd262143;
        wait_done(lat);
        check("b2b first latency", lat, 25);
        check("b2b first signal", {24'd0, signal}, 53);
        $display("b2b first: latency=%0d signal=%0d", lat, signal);
        wait_done(lat);
        start = 1'b0;
        check("b2b second latency", lat, 26);
        check("b2b second signal", {24'd0, signal}, 255);
        $display("b2b second: latency=%0d signal=%0d", lat, signal);
        repeat (30) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
